// File: rtl/instruction_transmitter_pkg.sv
// Shared byte-bus definitions for the instruction transmit and receive sides:
// state encoding, default ack timeout and byte-lane selection.
package gpu_bus_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WAIT_RX = 3'd1;
    localparam logic [2:0] ST_SETUP   = 3'd2;
    localparam logic [2:0] ST_STROBE  = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;
    localparam logic [2:0] ST_ABORT   = 3'd6;

    localparam int DEFAULT_ACK_TIMEOUT = 255;
    localparam int TIMER_WIDTH         = 16;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_WAIT_RX = ST_WAIT_RX,
        S_SETUP   = ST_SETUP,
        S_STROBE  = ST_STROBE,
        S_RELEASE = ST_RELEASE,
        S_DONE    = ST_DONE,
        S_ABORT   = ST_ABORT
    } tx_state_t;

    // Byte index 0 is the first byte on the bus; msb_first picks which end of the word that is.
    function automatic logic [7:0] select_byte(input logic [31:0] word,
                                               input logic [1:0]  idx,
                                               input logic        msb_first);
        logic [1:0] lane;
        lane = msb_first ? (2'd3 - idx) : idx;
        return word[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/instruction_transmitter_if.sv
// Instruction handshake plus byte-bus signals between the transmitter (master) and its environment.
interface instruction_transmitter_if;
    logic [31:0] i_instruction;
    logic        i_valid;
    logic        o_ready;
    logic        i_busy;
    logic        o_we;
    logic        o_en;
    logic [7:0]  o_data;
    logic        i_ack;
    logic        o_done;
    logic        o_timeout;

    modport master (
        input  i_instruction, i_valid, i_busy, i_ack,
        output o_ready, o_we, o_en, o_data, o_done, o_timeout
    );

    modport slave (
        output i_instruction, i_valid, i_busy, i_ack,
        input  o_ready, o_we, o_en, o_data, o_done, o_timeout
    );
endinterface

// File: rtl/instruction_transmitter_ack_watchdog.sv
// Cycle counter bounding how long one ack phase may wait for the receiver.
module ack_watchdog
    import gpu_bus_pkg::*;
#(
    parameter int LIMIT = DEFAULT_ACK_TIMEOUT
) (
    input  logic i_clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);
    // The phase is over once the cycle being counted now would be the LIMIT-th.
    localparam logic [TIMER_WIDTH-1:0] LAST = 16'(LIMIT - 1);

    logic [TIMER_WIDTH-1:0] count_r;

    // Count waiting cycles; clear wins over run.
    always_ff @(posedge i_clk) begin
        if (!reset) begin
            count_r <= 16'd0;
        end else if (clear) begin
            count_r <= 16'd0;
        end else if (run) begin
            count_r <= count_r + 16'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == LAST);

endmodule

// File: rtl/instruction_transmitter.sv
// Sends a latched 32-bit instruction as four acknowledged byte-bus writes.
// All bus outputs are registered, decoded from the next state so they line up with the state register.
module instruction_transmitter
    import gpu_bus_pkg::*;
#(
    parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic i_clk,
    input  logic reset,
    instruction_transmitter_if.master bus
);
    tx_state_t   state_r, state_s;
    logic [31:0] word_r, word_s;
    logic [1:0]  idx_r, idx_s;
    logic        wd_clear_s, wd_run_s, wd_expired_s;
    logic        ready_s, we_s, en_s, done_s, timeout_s;
    logic [7:0]  data_s;
    logic        ready_r, we_r, en_r, done_r, timeout_r;
    logic [7:0]  data_r;

    ack_watchdog #(.LIMIT(ACK_TIMEOUT)) u_ack_watchdog (
        .i_clk   (i_clk),
        .reset   (reset),
        .clear   (wd_clear_s),
        .run     (wd_run_s),
        .expired (wd_expired_s)
    );

    // Next-state, word latch, byte index and watchdog control.
    always_comb begin
        state_s    = state_r;
        word_s     = word_r;
        idx_s      = idx_r;
        wd_clear_s = 1'b0;
        wd_run_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (bus.i_valid) begin
                    word_s  = bus.i_instruction;
                    idx_s   = 2'd0;
                    state_s = S_WAIT_RX;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WAIT_RX: begin
                if (!bus.i_busy) begin
                    state_s = S_SETUP;
                end else begin
                    state_s = S_WAIT_RX;
                end
            end
            S_SETUP: begin
                wd_clear_s = 1'b1;
                state_s    = S_STROBE;
            end
            S_STROBE: begin
                if (bus.i_ack) begin
                    wd_clear_s = 1'b1;
                    state_s    = S_RELEASE;
                end else if (wd_expired_s) begin
                    state_s = S_ABORT;
                end else begin
                    wd_run_s = 1'b1;
                    state_s  = S_STROBE;
                end
            end
            S_RELEASE: begin
                if (!bus.i_ack) begin
                    if (idx_r == 2'd3) begin
                        state_s = S_DONE;
                    end else begin
                        idx_s   = idx_r + 2'd1;
                        state_s = S_SETUP;
                    end
                end else if (wd_expired_s) begin
                    state_s = S_ABORT;
                end else begin
                    wd_run_s = 1'b1;
                    state_s  = S_RELEASE;
                end
            end
            S_DONE, S_ABORT: begin
                word_s  = 32'd0;
                idx_s   = 2'd0;
                state_s = S_IDLE;
            end
            default: begin
                word_s  = 32'd0;
                idx_s   = 2'd0;
                state_s = S_IDLE;
            end
        endcase
    end

    // Output decode for the state about to be entered.
    always_comb begin
        ready_s   = 1'b0;
        we_s      = 1'b0;
        en_s      = 1'b0;
        done_s    = 1'b0;
        timeout_s = 1'b0;
        case (state_s)
            S_IDLE:    ready_s   = 1'b1;
            S_SETUP:   we_s      = 1'b1;
            S_STROBE:  begin we_s = 1'b1; en_s = 1'b1; end
            S_RELEASE: we_s      = 1'b1;
            S_DONE:    done_s    = 1'b1;
            S_ABORT:   timeout_s = 1'b1;
            default:   ready_s   = 1'b0;
        endcase
        data_s = we_s ? select_byte(word_s, idx_s, MSB_FIRST) : 8'h00;
    end

    // Control state registers.
    always_ff @(posedge i_clk) begin
        if (!reset) begin
            state_r <= S_IDLE;
            word_r  <= 32'd0;
            idx_r   <= 2'd0;
        end else begin
            state_r <= state_s;
            word_r  <= word_s;
            idx_r   <= idx_s;
        end
    end

    // Registered bus outputs.
    always_ff @(posedge i_clk) begin
        if (!reset) begin
            ready_r   <= 1'b1;
            we_r      <= 1'b0;
            en_r      <= 1'b0;
            data_r    <= 8'h00;
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            ready_r   <= ready_s;
            we_r      <= we_s;
            en_r      <= en_s;
            data_r    <= data_s;
            done_r    <= done_s;
            timeout_r <= timeout_s;
        end
    end

    assign bus.o_ready   = ready_r;
    assign bus.o_we      = we_r;
    assign bus.o_en      = en_r;
    assign bus.o_data    = data_r;
    assign bus.o_done    = done_r;
    assign bus.o_timeout = timeout_r;

endmodule
